// File: rtl/xadc_temp_averager.sv
// Block-averages qualified XADC conversions and converts the average to a display value:
// raw counts, tenths of degC or tenths of degF for a 10 mV/degC sensor with a 500 mV offset.
module xadc_temp_averager #(
    parameter logic [4:0] CHANNEL  = 5'h15,
    parameter int         AVG_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eoc_in,
    input  logic [4:0]  channel_in,
    input  logic [15:0] adc_data_in,
    input  logic [1:0]  unit_sel,
    output logic [11:0] avg_raw,
    output logic [15:0] value_out,
    output logic        value_valid
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int LAST  = (1 << AVG_LOG2) - 1;

    typedef enum logic [2:0] {S_ACCUM, S_MV, S_CEL, S_FAR, S_OUT} state_t;

    // avg * 1000 / 4096, truncating; 0..999 mV for a full-scale 1 V input
    function automatic logic [9:0] to_mv(input logic [11:0] a);
        logic [21:0] p;
        p = 22'(a) * 22'd1000;
        return p[21:12];
    endfunction

    function automatic logic signed [15:0] to_cel(input logic [9:0] mv);
        return $signed({6'b0, mv}) - 16'sd500;
    endfunction

    // Signed division truncates toward zero, matching the reference conversion
    function automatic logic signed [15:0] to_far(input logic signed [15:0] c);
        logic signed [15:0] t;
        t = c * 16'sd9;
        return (t / 16'sd5) + 16'sd320;
    endfunction

    logic [ACC_W-1:0]   acc_q, acc_d, sum;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        sample;
    logic               accept, block_end;
    logic               unused_nib;

    state_t             state_q;
    logic [11:0]        avg_p0_q;
    logic [9:0]         mv_p1_q;
    logic signed [15:0] cel_p2_q;
    logic signed [15:0] far_p3_q;
    logic [11:0]        avg_raw_q;
    logic [15:0]        value_q;
    logic               valid_q;

    assign unused_nib = ^adc_data_in[3:0];

    always_comb begin
        sample    = adc_data_in[15:4];
        accept    = eoc_in && (channel_in == CHANNEL);
        sum       = acc_q + ACC_W'(sample);
        block_end = accept && (cnt_q == CNT_W'(LAST));
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        if (block_end) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= S_ACCUM;
            avg_raw_q <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            case (state_q)
                // p0: latch block average; a block ending outside ACCUM is dropped
                S_ACCUM: begin
                    if (block_end) begin
                        avg_p0_q <= 12'(sum >> AVG_LOG2);
                        state_q  <= S_MV;
                    end
                end
                // p1: millivolts
                S_MV: begin
                    mv_p1_q <= to_mv(avg_p0_q);
                    state_q <= S_CEL;
                end
                // p2: tenths of degC
                S_CEL: begin
                    cel_p2_q <= to_cel(mv_p1_q);
                    state_q  <= S_FAR;
                end
                // p3: tenths of degF
                S_FAR: begin
                    far_p3_q <= to_far(cel_p2_q);
                    state_q  <= S_OUT;
                end
                // Output: unit_sel is sampled only here
                S_OUT: begin
                    case (unit_sel)
                        2'b01:   value_q <= cel_p2_q;
                        2'b10:   value_q <= far_p3_q;
                        default: value_q <= {4'b0, avg_p0_q};
                    endcase
                    avg_raw_q <= avg_p0_q;
                    valid_q   <= 1'b1;
                    state_q   <= S_ACCUM;
                end
                default: state_q <= S_ACCUM;
            endcase
        end
    end

    assign avg_raw     = avg_raw_q;
    assign value_out   = value_q;
    assign value_valid = valid_q;

endmodule

// File: tb/tb_xadc_temp_averager.sv
// Randomized scenario bench for xadc_temp_averager with a plain-arithmetic reference model.
module tb_xadc_temp_averager;

    logic        clk = 1'b0;
    logic        reset;
    logic        eoc_in;
    logic [4:0]  channel_in;
    logic [15:0] adc_data_in;
    logic [1:0]  unit_sel;
    logic [11:0] avg_raw;
    logic [15:0] value_out;
    logic        value_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [15:0] last_val;
    logic [11:0] last_raw;

    xadc_temp_averager dut (
        .clk(clk), .reset(reset), .eoc_in(eoc_in), .channel_in(channel_in),
        .adc_data_in(adc_data_in), .unit_sel(unit_sel), .avg_raw(avg_raw),
        .value_out(value_out), .value_valid(value_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (value_valid === 1'b1) begin
            pulses   <= pulses + 1;
            last_val <= value_out;
            last_raw <= avg_raw;
        end
    end

    function automatic logic [15:0] model_val(input int avg, input logic [1:0] sel);
        int mv, c, f;
        mv = (avg * 1000) / 4096;
        c  = mv - 500;
        f  = (c * 9) / 5 + 320;
        case (sel)
            2'b01:   return 16'(c);
            2'b10:   return 16'(f);
            default: return 16'(avg);
        endcase
    endfunction

    function automatic logic [4:0] other_ch();
        logic [4:0] ch;
        ch = 5'($urandom_range(0, 31));
        if (ch == 5'h15) ch = 5'h10;
        return ch;
    endfunction

    task automatic pulse(input logic [4:0] ch, input logic [15:0] d);
        @(negedge clk);
        eoc_in      = 1'b1;
        channel_in  = ch;
        adc_data_in = d;
        @(negedge clk);
        eoc_in      = 1'b0;
        adc_data_in = 16'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_block(input logic [15:0] s[16], input logic [1:0] sel,
                             input bit noise, input string name);
        int sum;
        int p0;
        logic [11:0] eavg;
        logic [15:0] ev;
        sum = 0;
        p0 = pulses;
        unit_sel = sel;
        for (int i = 0; i < 16; i++) begin
            sum += int'(s[i][15:4]);
            if (noise && $urandom_range(0, 2) == 0) pulse(other_ch(), 16'($urandom));
            pulse(5'h15, s[i]);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        eavg = 12'(sum / 16);
        ev   = model_val(int'(eavg), sel);
        repeat (8) @(negedge clk);
        checks++;
        if (pulses !== p0 + 1) begin
            errors++;
            $display("FAIL %s pulse count: got %0d expected %0d", name, pulses - p0, 1);
        end
        checks++;
        if (last_raw !== eavg) begin
            errors++;
            $display("FAIL %s avg_raw: got %h expected %h", name, last_raw, eavg);
        end
        checks++;
        if (last_val !== ev) begin
            errors++;
            $display("FAIL %s value_out: got %h expected %h", name, last_val, ev);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (avg_raw !== 12'h000) begin errors++; $display("FAIL reset avg_raw: got %h expected 000", avg_raw); end
        checks++;
        if (value_out !== 16'h0000) begin errors++; $display("FAIL reset value_out: got %h expected 0000", value_out); end
        checks++;
        if (value_valid !== 1'b0) begin errors++; $display("FAIL reset value_valid: got %b expected 0", value_valid); end
    endtask

    task automatic test_latency();
        unit_sel = 2'b01;
        for (int i = 0; i < 16; i++) pulse(5'h15, 16'h8000);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (value_valid !== (k == 4)) begin
                errors++;
                $display("FAIL latency cycle %0d: got %b expected %b", k, value_valid, (k == 4));
            end
        end
        checks++;
        if (value_out !== 16'h0000) begin errors++; $display("FAIL latency value_out: got %h expected 0000", value_out); end
        checks++;
        if (avg_raw !== 12'h800) begin errors++; $display("FAIL latency avg_raw: got %h expected 800", avg_raw); end
    endtask

    task automatic test_units();
        logic [15:0] s[16];
        foreach (s[i]) s[i] = 16'hFFF0;
        run_block(s, 2'b10, 1'b0, "full_far");
        checks++;
        if (last_val !== 16'd1218) begin errors++; $display("FAIL full_far const: got %h expected %h", last_val, 16'd1218); end
        foreach (s[i]) s[i] = 16'h0000;
        run_block(s, 2'b01, 1'b0, "zero_cel");
        checks++;
        if (last_val !== 16'hFE0C) begin errors++; $display("FAIL zero_cel const: got %h expected FE0C", last_val); end
        run_block(s, 2'b10, 1'b0, "zero_far");
        checks++;
        if (last_val !== 16'hFDBC) begin errors++; $display("FAIL zero_far const: got %h expected FDBC", last_val); end
    endtask

    task automatic test_channel_filter();
        int p0;
        p0 = pulses;
        unit_sel = 2'b00;
        for (int i = 0; i < 16; i++) begin
            pulse(5'h10, 16'hFFF0);
            pulse(5'h15, 16'h8000);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (pulses !== p0 + 1) begin errors++; $display("FAIL chan pulses: got %0d expected 1", pulses - p0); end
        checks++;
        if (last_raw !== 12'h800) begin errors++; $display("FAIL chan avg_raw: got %h expected 800", last_raw); end
    endtask

    task automatic test_reset_midblock();
        logic [15:0] s[16];
        int p0;
        foreach (s[i]) s[i] = (i < 8) ? 16'h1000 : 16'h3000;
        run_block(s, 2'b00, 1'b1, "mix");
        checks++;
        if (last_raw !== 12'h200) begin errors++; $display("FAIL mix const: got %h expected 200", last_raw); end
        p0 = pulses;
        for (int i = 0; i < 10; i++) pulse(5'h15, 16'hFFF0);
        do_reset();
        repeat (20) @(negedge clk);
        checks++;
        if (pulses !== p0) begin errors++; $display("FAIL midblock reset pulses: got %0d expected 0", pulses - p0); end
        foreach (s[i]) s[i] = 16'($urandom);
        run_block(s, 2'b01, 1'b0, "after_reset");
        p0 = pulses;
        for (int i = 0; i < 16; i++) pulse(5'h15, 16'h4000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (pulses !== p0) begin errors++; $display("FAIL midconvert reset pulses: got %0d expected 0", pulses - p0); end
        checks++;
        if (avg_raw !== 12'h000) begin errors++; $display("FAIL midconvert avg_raw: got %h expected 000", avg_raw); end
    endtask

    task automatic test_unit_sel();
        logic [15:0] s[16];
        int p0;
        foreach (s[i]) s[i] = 16'hABC0;
        run_block(s, 2'b00, 1'b0, "raw_sel");
        checks++;
        if (last_val !== 16'h0ABC) begin errors++; $display("FAIL raw_sel const: got %h expected 0ABC", last_val); end
        p0 = pulses;
        for (int i = 0; i < 16; i++) begin
            unit_sel = 2'($urandom);
            pulse(5'h15, 16'hABC0);
        end
        unit_sel = 2'b01;
        @(negedge clk);
        unit_sel = 2'b10;
        repeat (8) @(negedge clk);
        checks++;
        if (last_val !== 16'd626) begin errors++; $display("FAIL sel_toggle value: got %h expected %h", last_val, 16'd626); end
        unit_sel = 2'b00;
        repeat (5) @(negedge clk);
        checks++;
        if (value_out !== 16'd626 || pulses !== p0 + 1) begin
            errors++;
            $display("FAIL sel_hold value: got %h/%0d expected %h/1", value_out, pulses - p0, 16'd626);
        end
    endtask

    task automatic test_random();
        logic [15:0] s[16];
        for (int b = 0; b < 6; b++) begin
            foreach (s[i]) s[i] = 16'($urandom);
            run_block(s, 2'($urandom), 1'b1, "random");
        end
    endtask

    initial begin
        reset       = 1'b1;
        eoc_in      = 1'b0;
        channel_in  = 5'h15;
        adc_data_in = 16'h0000;
        unit_sel    = 2'b00;
        test_reset();
        test_latency();
        test_units();
        test_channel_filter();
        test_reset_midblock();
        test_unit_sel();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
